// File: rtl/fir_pkg.sv
// Shared definitions for the FIR output stage: Q15 limits, default shift, FIFO entry.
package fir_pkg;

    localparam int SAMPLE_MAX     = 32767;
    localparam int SAMPLE_MIN     = -32768;
    localparam int FRAC_SHIFT_DEF = 15;

    typedef struct packed {
        logic               sat;
        logic signed [15:0] data;
    } fifo_entry_t;

    localparam int ENTRY_W = $bits(fifo_entry_t);

endpackage

// File: rtl/fir_sync_fifo.sv
// Single-clock circular-buffer FIFO with occupancy, full and empty flags.
// A write while full is only accepted when a read frees a slot in the same cycle.
module fir_sync_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_clear,
    input  logic                     i_wr_en,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic                     i_rd_en,
    output logic [WIDTH-1:0]         o_rd_data,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic             w_rd;
    logic             w_wr;

    assign o_full  = (r_level == LW'(DEPTH));
    assign o_empty = (r_level == '0);
    assign w_rd    = i_rd_en && !o_empty && !i_clear;
    assign w_wr    = i_wr_en && (!o_full || w_rd) && !i_clear;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_wr, w_rd})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Empty head reads as zero so the outputs have a defined value after reset.
    assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr];
    assign o_level   = r_level;

endmodule

// File: rtl/fir_requant_decimator.sv
// Q30 -> Q15 round/saturate, keep 1 of DECIM samples, buffer in a FIFO drained by valid/ready.
// Optional saturation event counter enabled by defining FIR_REQUANT_SATCNT_EN.
// Handshake: a head entry transfers on every rising edge where out_valid && out_ready are both high.
module fir_requant_decimator
    import fir_pkg::*;
#(
    parameter int DECIM      = 2,
    parameter int FIFO_DEPTH = 8,
    parameter int FRAC_SHIFT = FRAC_SHIFT_DEF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clear,
    input  logic                          in_valid,
    input  logic [31:0]                   in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [15:0]                   out_data,
    output logic                          out_sat,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   sat_count
);

    localparam int PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic signed [32:0] RND    = 33'sd1 <<< (FRAC_SHIFT - 1);
    localparam logic signed [32:0] LIM_HI = 33'(SAMPLE_MAX);
    localparam logic signed [32:0] LIM_LO = 33'(SAMPLE_MIN);

    logic [PH_W-1:0]    r_phase;
    logic               r_s1_valid;
    fifo_entry_t        r_s1_entry;
    logic               r_overflow;

    logic signed [32:0] w_rounded;
    logic signed [32:0] w_shifted;
    fifo_entry_t        w_entry;
    fifo_entry_t        w_head;
    logic               w_keep;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_drop;
    logic               w_accept;

    // 33 bits leave headroom for the rounding add on the largest positive input.
    assign w_rounded = $signed({in_data[31], in_data}) + RND;
    assign w_shifted = w_rounded >>> FRAC_SHIFT;

    always_comb begin
        w_entry = '0;
        if (w_shifted > LIM_HI) begin
            w_entry.data = 16'(SAMPLE_MAX);
            w_entry.sat  = 1'b1;
        end else if (w_shifted < LIM_LO) begin
            w_entry.data = 16'(SAMPLE_MIN);
            w_entry.sat  = 1'b1;
        end else begin
            w_entry.data = w_shifted[15:0];
        end
    end

    assign w_keep = in_valid && (r_phase == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_phase    <= '0;
            r_s1_valid <= 1'b0;
            r_s1_entry <= '0;
        end else if (clear) begin
            r_phase    <= '0;
            r_s1_valid <= 1'b0;
        end else begin
            r_s1_valid <= w_keep;
            if (w_keep) r_s1_entry <= w_entry;
            if (in_valid) begin
                r_phase <= (r_phase == PH_W'(DECIM - 1)) ? '0 : r_phase + PH_W'(1);
            end
        end
    end

    assign w_push   = r_s1_valid && !clear;
    assign w_pop    = !w_empty && out_ready && !clear;
    assign w_drop   = w_push && w_full && !w_pop;
    assign w_accept = w_push && !w_drop;

    fir_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (clear),
        .i_wr_en   (w_push),
        .i_wr_data (r_s1_entry),
        .i_rd_en   (out_ready),
        .o_rd_data (w_head),
        .o_level   (fifo_level),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overflow <= 1'b0;
        end else if (clear) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

`ifdef FIR_REQUANT_SATCNT_EN
    logic [15:0] r_sat_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sat_count <= '0;
        end else if (clear) begin
            r_sat_count <= '0;
        end else if (w_accept && r_s1_entry.sat && (r_sat_count != 16'hFFFF)) begin
            r_sat_count <= r_sat_count + 16'd1;
        end
    end

    assign sat_count = r_sat_count;
`else
    logic w_unused_accept;
    assign w_unused_accept = w_accept;
    assign sat_count       = 16'h0000;
`endif

    assign out_valid = !w_empty;
    assign out_data  = w_head.data;
    assign out_sat   = w_head.sat;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_fir_requant_decimator.sv
// Bench for fir_requant_decimator: a DECIM=1 and a DECIM=4 instance share one stimulus stream
// and are checked every cycle against a queue-based reference model, plus directed scenarios.
`timescale 1ns/1ps
module tb_fir_requant_decimator;

    localparam int DEPTH = 8;
    localparam int LW    = $clog2(DEPTH) + 1;

    // clock / reset
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        out_ready = 1'b0;

    logic          ov_a, ov_b, sat_a, sat_b, ovf_a, ovf_b;
    logic [15:0]   od_a, od_b, sc_a, sc_b;
    logic [LW-1:0] lvl_a, lvl_b;

    fir_requant_decimator #(.DECIM(1), .FIFO_DEPTH(DEPTH), .FRAC_SHIFT(15)) dut_a (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_data(in_data),
        .out_valid(ov_a), .out_ready(out_ready), .out_data(od_a), .out_sat(sat_a),
        .overflow(ovf_a), .fifo_level(lvl_a), .sat_count(sc_a)
    );

    fir_requant_decimator #(.DECIM(4), .FIFO_DEPTH(DEPTH), .FRAC_SHIFT(15)) dut_b (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_data(in_data),
        .out_valid(ov_b), .out_ready(out_ready), .out_data(od_b), .out_sat(sat_b),
        .overflow(ovf_b), .fifo_level(lvl_b), .sat_count(sc_b)
    );

    // scoreboard / reference model state
    int          n_cmp = 0;
    int          n_err = 0;
    int          decim [2] = '{1, 4};
    int          ph    [2];
    logic        s1v   [2];
    logic [16:0] s1e   [2];
    logic        movf  [2];
    int          msat  [2];
    logic [16:0] exp_q0 [$];
    logic [16:0] exp_q1 [$];
    logic [16:0] got_a [$];
    logic [16:0] got_b [$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Round half toward +inf of x/2^15 using plain integer division, then clamp to Q15.
    function automatic logic [16:0] ref_requant(input logic [31:0] x);
        longint v, t, r;
        logic   s;
        v = longint'($signed(x));
        t = v + 16384;
        if (t >= 0) r = t / 32768;
        else        r = -((-t + 32767) / 32768);
        s = 1'b0;
        if (r > 32767) begin
            r = 32767;
            s = 1'b1;
        end else if (r < -32768) begin
            r = -32768;
            s = 1'b1;
        end
        return {s, r[15:0]};
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            ph[d] = 0; s1v[d] = 1'b0; s1e[d] = '0; movf[d] = 1'b0; msat[d] = 0;
        end
        exp_q0.delete();
        exp_q1.delete();
    endtask

    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            int sz;
            sz = (d == 0) ? exp_q0.size() : exp_q1.size();
            if (clear) begin
                ph[d] = 0; s1v[d] = 1'b0; movf[d] = 1'b0; msat[d] = 0;
                if (d == 0) exp_q0.delete(); else exp_q1.delete();
            end else begin
                if (sz != 0 && out_ready) begin
                    if (d == 0) void'(exp_q0.pop_front()); else void'(exp_q1.pop_front());
                    sz--;
                end
                if (s1v[d]) begin
                    if (sz < DEPTH) begin
                        if (d == 0) exp_q0.push_back(s1e[d]); else exp_q1.push_back(s1e[d]);
                        if (s1e[d][16] && msat[d] < 65535) msat[d]++;
                    end else begin
                        movf[d] = 1'b1;
                    end
                end
                s1v[d] = in_valid && (ph[d] == 0);
                if (in_valid && ph[d] == 0) s1e[d] = ref_requant(in_data);
                if (in_valid) ph[d] = (ph[d] + 1) % decim[d];
            end
        end
    endtask

    function automatic logic [31:0] exp_satc(input int d);
`ifdef FIR_REQUANT_SATCNT_EN
        return 32'(msat[d]);
`else
        return 32'(d - d);
`endif
    endfunction

    task automatic compare_all();
        check_eq("a_valid", 32'(ov_a), 32'(exp_q0.size() != 0));
        check_eq("a_level", 32'(lvl_a), 32'(exp_q0.size()));
        check_eq("a_ovf",   32'(ovf_a), 32'(movf[0]));
        check_eq("a_satc",  32'(sc_a),  exp_satc(0));
        if (exp_q0.size() != 0) check_eq("a_head", 32'({sat_a, od_a}), 32'(exp_q0[0]));
        check_eq("b_valid", 32'(ov_b), 32'(exp_q1.size() != 0));
        check_eq("b_level", 32'(lvl_b), 32'(exp_q1.size()));
        check_eq("b_ovf",   32'(ovf_b), 32'(movf[1]));
        check_eq("b_satc",  32'(sc_b),  exp_satc(1));
        if (exp_q1.size() != 0) check_eq("b_head", 32'({sat_b, od_b}), 32'(exp_q1[0]));
    endtask

    // Inputs are driven just after a falling edge; one call advances one rising edge.
    task automatic tick();
        if (reset && !clear && out_ready && ov_a) got_a.push_back({sat_a, od_a});
        if (reset && !clear && out_ready && ov_b) got_b.push_back({sat_b, od_b});
        @(posedge clk);
        if (!reset) model_reset();
        else        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input logic [31:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    logic [31:0] rnd_in  [5] = '{32'h0000_4000, 32'hFFFF_C000, 32'h3FFF_8000, 32'h4000_0000, 32'hBFFF_8000};
    logic [16:0] rnd_exp [5] = '{17'h0_0001, 17'h0_0000, 17'h0_7FFF, 17'h1_7FFF, 17'h1_8000};

    initial begin
        model_reset();
        @(negedge clk);
        idle(3);
        check_eq("rst_valid", 32'(ov_a), 32'h0);
        check_eq("rst_data",  32'({sat_a, od_a}), 32'h0);
        reset = 1'b1;
        idle(1);

        // rounding and saturation on DECIM=1
        out_ready = 1'b1;
        got_a.delete();
        for (int i = 0; i < 5; i++) send(rnd_in[i]);
        idle(4);
        check_eq("round_count", 32'(got_a.size()), 32'd5);
        for (int i = 0; i < 5; i++)
            if (i < got_a.size()) check_eq("round_val", 32'(got_a[i]), 32'(rnd_exp[i]));
`ifdef FIR_REQUANT_SATCNT_EN
        check_eq("sat_count2", 32'(sc_a), 32'd2);
`else
        check_eq("sat_count0", 32'(sc_a), 32'd0);
`endif

        // decimation by 4 on a ramp
        pulse_clear();
        got_b.delete();
        for (int k = 0; k < 12; k++) send(32'h0000_8000 * k);
        idle(4);
        check_eq("decim_count", 32'(got_b.size()), 32'd3);
        for (int i = 0; i < 3; i++)
            if (i < got_b.size()) check_eq("decim_val", 32'(got_b[i]), 32'({1'b0, 16'(4 * i)}));

        // back-pressure and overflow
        pulse_clear();
        out_ready = 1'b0;
        for (int k = 0; k < 10; k++) send(32'((100 + k) << 15));
        idle(3);
        check_eq("bp_level", 32'(lvl_a), 32'd8);
        check_eq("bp_ovf",   32'(ovf_a), 32'd1);
        got_a.delete();
        out_ready = 1'b1;
        idle(10);
        check_eq("bp_count", 32'(got_a.size()), 32'd8);
        for (int i = 0; i < 8; i++)
            if (i < got_a.size()) check_eq("bp_order", 32'(got_a[i]), 32'(100 + i));

        // full FIFO with simultaneous write and read
        pulse_clear();
        out_ready = 1'b0;
        for (int k = 0; k < 8; k++) send(32'((200 + k) << 15));
        idle(2);
        check_eq("full_level", 32'(lvl_a), 32'd8);
        send(32'(208 << 15));
        got_a.delete();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        idle(1);
        check_eq("rw_level", 32'(lvl_a), 32'd8);
        check_eq("rw_ovf",   32'(ovf_a), 32'd0);
        out_ready = 1'b1;
        idle(10);
        check_eq("rw_count", 32'(got_a.size()), 32'd9);
        for (int i = 0; i < 9; i++)
            if (i < got_a.size()) check_eq("rw_order", 32'(got_a[i]), 32'(200 + i));

        // asynchronous reset mid-stream
        pulse_clear();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) send(32'((20 + k) << 15));
        idle(2);
        check_eq("prerst_level", 32'(lvl_a), 32'd3);
        reset = 1'b0;
        #1;
        check_eq("arst_valid", 32'(ov_a), 32'd0);
        check_eq("arst_level", 32'(lvl_a), 32'd0);
        check_eq("arst_level_b", 32'(lvl_b), 32'd0);
        model_reset();
        tick();
        reset = 1'b1;
        idle(1);

        // clear mid-stream, with the in_valid in the clear cycle ignored
        for (int k = 0; k < 3; k++) send(32'((40 + k) << 15));
        idle(2);
        check_eq("preclr_level_a", 32'(lvl_a), 32'd3);
        check_eq("preclr_level_b", 32'(lvl_b), 32'd1);
        clear = 1'b1;
        in_valid = 1'b1;
        in_data = 32'(999 << 15);
        tick();
        clear = 1'b0;
        in_valid = 1'b0;
        check_eq("clr_valid", 32'(ov_a), 32'd0);
        check_eq("clr_level", 32'(lvl_a), 32'd0);
        check_eq("clr_level_b", 32'(lvl_b), 32'd0);
        out_ready = 1'b1;
        got_b.delete();
        for (int k = 0; k < 5; k++) send(32'((300 + k) << 15));
        idle(4);
        check_eq("clr_phase_count", 32'(got_b.size()), 32'd2);
        if (got_b.size() > 0) check_eq("clr_phase_0", 32'(got_b[0]), 32'd300);
        if (got_b.size() > 1) check_eq("clr_phase_1", 32'(got_b[1]), 32'd304);

        // randomized traffic, stalls and occasional clears
        for (int n = 0; n < 800; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0:       in_data = $urandom;
                1:       in_data = 32'($urandom_range(0, 32'h000F_FFFF));
                2:       in_data = -32'($urandom_range(0, 32'h000F_FFFF));
                default: in_data = 32'h3FFF_0000 + 32'($urandom_range(0, 32'h0001_FFFF));
            endcase
            out_ready = ($urandom_range(0, 2) != 0);
            clear     = ($urandom_range(0, 99) == 0);
            tick();
        end
        clear = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        idle(12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
